// File: rtl/mr_reorder_pkg.sv
// Shared constants for the digit-reversal reorder buffer: mode encoding,
// per-mode frame length, digit radices and address weights, bank states.
package mr_reorder_pkg;

    localparam int CW = 6;

    typedef enum logic [1:0] {
        MODE_IDENT = 2'd0,
        MODE_R33   = 2'd1,
        MODE_R53   = 2'd2,
        MODE_R335  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Tables are indexed by mode; literal order is {R335, R53, R33, IDENT}.
    // MAXn = radix-1 of digit n, Wn = address weight of digit n,
    // Bn = Wn*(radix-1), the amount removed when digit n wraps.
    localparam logic [3:0][CW-1:0] N_TBL    = {6'd45, 6'd15, 6'd9,  6'd45};
    localparam logic [3:0][CW-1:0] MAX0_TBL = {6'd2,  6'd4,  6'd2,  6'd44};
    localparam logic [3:0][CW-1:0] MAX1_TBL = {6'd2,  6'd2,  6'd2,  6'd0};
    localparam logic [3:0][CW-1:0] MAX2_TBL = {6'd4,  6'd0,  6'd0,  6'd0};
    localparam logic [3:0][CW-1:0] W0_TBL   = {6'd15, 6'd3,  6'd3,  6'd1};
    localparam logic [3:0][CW-1:0] W1_TBL   = {6'd5,  6'd1,  6'd1,  6'd0};
    localparam logic [3:0][CW-1:0] W2_TBL   = {6'd1,  6'd0,  6'd0,  6'd0};
    localparam logic [3:0][CW-1:0] B0_TBL   = {6'd30, 6'd12, 6'd6,  6'd44};
    localparam logic [3:0][CW-1:0] B1_TBL   = {6'd10, 6'd2,  6'd2,  6'd0};

endpackage

// File: rtl/mr_reorder_buf_if.sv
// Sample stream bundle for the reorder buffer: input side (natural order)
// and output side (digit-reversed order) plus the frame mode select.
interface mr_reorder_buf_if #(
    parameter int DATA_W = 16
);
    // Both sides: a beat transfers only in a cycle where valid and ready are
    // both high; a source holds valid and its payload until that happens.
    logic [1:0]        mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mr_digit_rev_cnt.sv
// Write-address generator: three mixed-radix digit counters drive a weighted
// accumulator so the address follows the digit-reversed permutation.
module mr_digit_rev_cnt
    import mr_reorder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  mode_t             mode,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [CW-1:0]     d0, d1, d2;
    logic [CW-1:0]     d0_n, d1_n, d2_n;
    logic [ADDR_W-1:0] addr_n;

    assign last = (d0 == MAX0_TBL[mode]) && (d1 == MAX1_TBL[mode]) &&
                  (d2 == MAX2_TBL[mode]);

    // A wrapping digit removes its accumulated weight and the next digit
    // adds its own; the frame-final step is handled by clear.
    always_comb begin
        d0_n   = d0;
        d1_n   = d1;
        d2_n   = d2;
        addr_n = addr;
        if (d0 != MAX0_TBL[mode]) begin
            d0_n   = d0 + 1'b1;
            addr_n = addr + ADDR_W'(W0_TBL[mode]);
        end else if (d1 != MAX1_TBL[mode]) begin
            d0_n   = '0;
            d1_n   = d1 + 1'b1;
            addr_n = addr - ADDR_W'(B0_TBL[mode]) + ADDR_W'(W1_TBL[mode]);
        end else begin
            d0_n   = '0;
            d1_n   = '0;
            d2_n   = d2 + 1'b1;
            addr_n = addr - ADDR_W'(B0_TBL[mode]) - ADDR_W'(B1_TBL[mode]) +
                     ADDR_W'(W2_TBL[mode]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            addr <= '0;
        end else if (clear) begin
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            addr <= '0;
        end else if (step) begin
            d0   <= d0_n;
            d1   <= d1_n;
            d2   <= d2_n;
            addr <= addr_n;
        end
    end
endmodule

// File: rtl/mr_reorder_buf.sv
// Ping-pong frame reorder buffer: frames are written in permuted address
// order and read back sequentially through a registered output stage.
module mr_reorder_buf
    import mr_reorder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 45,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    mr_reorder_buf_if.slave bus,
    output logic [3:0]      bank_states
);
    logic [DATA_W-1:0] mem [2][MAX_N];
    bank_state_t       state [2];
    mode_t             bank_mode [2];

    logic              run;
    logic              wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_last;
    mode_t             wr_mode;
    logic              in_ready, wr_fire, wr_done;
    logic              out_valid, out_last, out_fire;
    logic [DATA_W-1:0] out_data;
    logic              ld_bank, ld_avail, ld, ld_last;

    assign in_ready = run && (state[wr_ptr] == BANK_EMPTY || state[wr_ptr] == BANK_FILLING);
    assign wr_fire  = bus.in_valid && in_ready;
    assign wr_done  = wr_fire && wr_last;
    // The live mode only steers the first beat; after that the bank's copy rules.
    assign wr_mode  = (state[wr_ptr] == BANK_EMPTY) ? mode_t'(bus.mode) : bank_mode[wr_ptr];

    // While the output register holds a frame's last word, the next load
    // comes from the other bank so back-to-back frames have no bubble.
    assign out_fire = out_valid && bus.out_ready;
    assign ld_bank  = (out_valid && out_last) ? !rd_ptr : rd_ptr;
    assign ld_avail = (state[ld_bank] == BANK_FULL) || (state[ld_bank] == BANK_DRAINING) ||
                      (wr_done && (wr_ptr == ld_bank));
    assign ld       = (!out_valid || bus.out_ready) && ld_avail;
    assign ld_last  = (rd_addr == ADDR_W'(N_TBL[bank_mode[ld_bank]]) - 1'b1);

    mr_digit_rev_cnt #(.ADDR_W(ADDR_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wr_done),
        .step  (wr_fire),
        .mode  (wr_mode),
        .addr  (wr_addr),
        .last  (wr_last)
    );

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr][wr_addr] <= bus.in_data;
        end
    end

    // Read-side updates come last so a load wins over a same-cycle FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run          <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            rd_addr      <= '0;
            state[0]     <= BANK_EMPTY;
            state[1]     <= BANK_EMPTY;
            bank_mode[0] <= MODE_IDENT;
            bank_mode[1] <= MODE_IDENT;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
        end else begin
            run <= 1'b1;
            if (wr_fire) begin
                if (state[wr_ptr] == BANK_EMPTY) begin
                    bank_mode[wr_ptr] <= wr_mode;
                end
                state[wr_ptr] <= wr_last ? BANK_FULL : BANK_FILLING;
                if (wr_last) begin
                    wr_ptr <= !wr_ptr;
                end
            end
            if (out_fire && out_last) begin
                state[rd_ptr] <= BANK_EMPTY;
                rd_ptr        <= !rd_ptr;
            end
            if (ld) begin
                state[ld_bank] <= BANK_DRAINING;
                out_data       <= mem[ld_bank][rd_addr];
                out_last       <= ld_last;
                out_valid      <= 1'b1;
                rd_addr        <= ld_last ? '0 : rd_addr + 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bank_states   = {state[1], state[0]};
endmodule
